// File: rtl/s_prod_acc4.sv
// Frame accumulator for signed 8-bit products from the 4x4 multiplier.
// Sums up to MAX_TERMS products per frame and holds the result until the consumer takes it.
module s_prod_acc4 #(
    parameter int unsigned MAX_TERMS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  prod,
    input  logic        last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] acc_out,
    output logic [4:0]  out_count
);

    localparam int unsigned PROD_W = 8;
    localparam int unsigned ACC_W  = 12;
    localparam int unsigned CNT_W  = 5;

    localparam logic [0:0] S_ACC  = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc_out;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_valid;

    logic [0:0]       w_state_nxt;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [ACC_W-1:0] w_acc_out_nxt;
    logic [CNT_W-1:0] w_out_count_nxt;
    logic             w_out_valid_nxt;

    logic [ACC_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_close;

    // Running sum wraps modulo 2^12; 16 worst-case terms still fit the signed range.
    assign w_sum     = r_acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_close   = last || (w_cnt_inc == CNT_W'(MAX_TERMS));

    assign in_ready  = (r_state == S_ACC) && !rst;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc_out;
    assign out_count = r_out_count;

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_acc_out_nxt   = r_acc_out;
        w_out_count_nxt = r_out_count;
        w_out_valid_nxt = r_out_valid;
        case (r_state)
            S_ACC: begin
                if (in_valid) begin
                    w_acc_nxt = w_sum;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_close) begin
                        w_state_nxt     = S_HOLD;
                        w_acc_out_nxt   = w_sum;
                        w_out_count_nxt = w_cnt_inc;
                        w_out_valid_nxt = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt     = S_ACC;
                    w_acc_nxt       = '0;
                    w_cnt_nxt       = '0;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_acc_out   <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc_out   <= w_acc_out_nxt;
            r_out_count <= w_out_count_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

endmodule

// File: doc/s_prod_acc4.md
S_PROD_ACC4 -- requirements
Module: s_prod_acc4

Interface
REQ-001 Parameter: MAX_TERMS, default 16, maximum number of products per frame; legal range 1..16.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; no other clock or async input.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  prod/last valid this cycle.
REQ-006 Port: in_ready  output  1  block accepts a product this cycle.
REQ-007 Port: prod  input  8  signed two's-complement product, i.e. the 8-bit output of the signed 4x4 Dadda/RCA multiplier.
REQ-008 Port: last  input  1  final product of the current frame; qualified by in_valid.
REQ-009 Port: out_valid  output  1  frame result valid.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: acc_out  output  12  signed frame sum, registered.
REQ-012 Port: out_count  output  5  number of products summed into acc_out, registered.

Function
REQ-013 The block SHALL have two states: ACC (accepting) and HOLD (result pending).
REQ-014 in_ready SHALL be 1 exactly when the state is ACC and rst is 0; it is a combinational decode of state only, with no path from out_ready.
REQ-015 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; inputs SHALL be ignored in any other cycle.
REQ-016 On each transfer: acc <= acc + sign_extend_12(prod) and cnt <= cnt + 1.
REQ-017 The sum SHALL be modulo 2^12; no overflow occurs because 16 x [-128,127] lies within the 12-bit signed range.
REQ-018 A transfer with last=1, or the transfer that makes cnt+1 = MAX_TERMS, SHALL close the frame: the state goes to HOLD and out_valid=1 from the next cycle.
REQ-019 On frame close: acc_out SHALL take the final sum, and out_count SHALL take the final count (1..16).
REQ-020 Latency SHALL be one cycle from the closing transfer edge to out_valid=1.
REQ-021 In HOLD: out_valid, acc_out and out_count SHALL hold stable until the edge where out_ready=1.
REQ-022 On that out_ready edge: out_valid <= 0; the internal acc and cnt clear to 0; the state returns to ACC.
REQ-023 in_ready SHALL therefore be 1 in the cycle after the output handshake, with no bubble beyond that.
REQ-024 out_ready SHALL be ignored while out_valid=0.
REQ-025 A frame with last=1 on its first transfer SHALL produce count 1.
REQ-026 last=1 on the MAX_TERMS-th transfer SHALL close exactly one frame; no empty frame follows.
REQ-027 acc_out and out_count SHALL keep their last values after the handshake until the next frame closes.
REQ-028 With MAX_TERMS=1, every transfer SHALL close a frame.

Reset
REQ-029 While rst=1 at a clock edge, the following SHALL all be 0 after that edge, regardless of in-flight state: acc, cnt, acc_out, out_count, out_valid.
REQ-030 While rst=1 at a clock edge, the state SHALL be ACC after that edge; in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst falls.
REQ-031 Reset in mid-frame or in HOLD SHALL discard the partial or pending result; the next frame SHALL start from sum 0 and count 0.

Verification
REQ-032 Single term: prod=0x0F, last=1, out_ready=0 -> next cycle out_valid=1, acc_out=0x00F, out_count=1, in_ready=0.
REQ-033 Mixed signs: prod 0x0F, 0xC8, 0x40 (15, -56, 64) with last on the third -> acc_out=0x017 (23), out_count=3.
REQ-034 Auto-close: 16 transfers of 0x80 with last=0 -> acc_out=0x800 (-2048), out_count=16, HOLD entered after the 16th.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid, acc_out and out_count stay stable, in_ready=0, and no input is absorbed; when out_ready=1, in_ready=1 on the next cycle.
REQ-036 Reset mid-frame: 2 transfers of 0x7F, then rst=1 for one cycle, then prod=0x01 with last=1 -> acc_out=0x001, out_count=1.
REQ-037 Random: 10k frames of random prod, last and out_ready against a reference model -> every frame's sum and count match, with no drops or duplicates.
